colour_sequence_gen: RTL

COLOUR_SEQUENCE_GEN -- requirements
Module: colour_sequence_gen

---
 rtl/colour_sequence_gen_pkg.sv | 26 ++
 rtl/colour_sequence_gen_lfsr16.sv | 25 ++
 rtl/colour_sequence_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/colour_sequence_gen_pkg.sv
// Shared definitions for the colour sequence generator: colour codes,
// size defaults, LFSR constants and the FSM state type.
package colour_sequence_gen_pkg;

  localparam logic [3:0] BLACK  = 4'h0;
  localparam logic [3:0] GREEN  = 4'h1;
  localparam logic [3:0] RED    = 4'h2;
  localparam logic [3:0] BLUE   = 4'h4;
  localparam logic [3:0] YELLOW = 4'h8;

  localparam int         DEFAULT_MAX_LEN   = 8;
  localparam logic [6:0] LEVEL_MAX         = 7'd99;
  localparam logic [15:0] LFSR_MASK         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic {
    ST_IDLE,
    ST_FILL
  } state_t;

  // Rotate a one-hot colour left by one position; YELLOW wraps to GREEN.
  function automatic logic [3:0] rotl_colour(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

endpackage

// File: rtl/colour_sequence_gen_lfsr16.sv
// 16-bit Galois LFSR, free-running on every clock, loaded with seed on reset.
module lfsr16
  import colour_sequence_gen_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] r_value;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_value <= seed;
    end else if (r_value[0]) begin
      r_value <= {1'b0, r_value[15:1]} ^ LFSR_MASK;
    end else begin
      r_value <= {1'b0, r_value[15:1]};
    end
  end

  assign value = r_value;

endmodule

// File: rtl/colour_sequence_gen.sv
// Generates a random colour sequence for a memory game, one slot per cycle.
// state   | meaning
// ST_IDLE | sequence stable, ready=1, accepts newGame/nextLevel
// ST_FILL | writing slot r_slot, requests ignored, ready=0
module colour_sequence_gen
  import colour_sequence_gen_pkg::*;
#(
  parameter int          MAX_LEN   = DEFAULT_MAX_LEN,
  parameter int          START_LEN = 3,
  parameter logic [15:0] SEED      = LFSR_DEFAULT_SEED
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 newGame,
  input  logic                 nextLevel,
  output logic [4*MAX_LEN-1:0] coloursequence,
  output logic [3:0]           seqLength,
  output logic [6:0]           level,
  output logic                 ready
);

  localparam logic [15:0] SEED_EFF    = (SEED == 16'h0) ? LFSR_DEFAULT_SEED : SEED;
  localparam logic [3:0]  MAX_LEN_L   = 4'(MAX_LEN);
  localparam logic [3:0]  START_LEN_L = 4'(START_LEN);
  localparam logic [3:0]  LAST_SLOT   = 4'(MAX_LEN - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_start_game;
  logic                 w_start_level;
  logic [3:0]           r_slot;
  logic [3:0]           r_len;
  logic [6:0]           r_level;
  logic [4*MAX_LEN-1:0] r_seq;
  logic [3:0]           r_prev1;
  logic [3:0]           r_prev2;
  logic [15:0]          w_lfsr;
  logic                 w_unused_lfsr;
  logic [3:0]           w_cand;
  logic                 w_triple;
  logic [3:0]           w_colour;

  lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset),
    .seed  (SEED_EFF),
    .value (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[15:2];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_start_game  = 1'b0;
    w_start_level = 1'b0;
    ready         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (newGame) begin
          w_start_game = 1'b1;
          w_state_nxt  = ST_FILL;
        end else if (nextLevel) begin
          w_start_level = 1'b1;
          w_state_nxt   = ST_FILL;
        end
      end
      ST_FILL: begin
        if (r_slot == LAST_SLOT) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_level <= 7'd0;
      r_len   <= 4'd0;
      r_slot  <= 4'd0;
    end else if (w_start_game) begin
      r_level <= 7'd1;
      r_len   <= START_LEN_L;
      r_slot  <= 4'd0;
    end else if (w_start_level) begin
      r_level <= (r_level >= LEVEL_MAX) ? LEVEL_MAX : r_level + 7'd1;
      r_len   <= (r_len >= MAX_LEN_L) ? MAX_LEN_L : r_len + 4'd1;
      r_slot  <= 4'd0;
    end else if (r_state == ST_FILL) begin
      r_slot  <= r_slot + 4'd1;
    end
  end

  always_comb begin
    w_cand = GREEN;
    case (w_lfsr[1:0])
      2'd0:    w_cand = GREEN;
      2'd1:    w_cand = RED;
      2'd2:    w_cand = BLUE;
      default: w_cand = YELLOW;
    endcase
  end

  // r_prev1/r_prev2 hold the two slots written just before r_slot in this fill.
  assign w_triple = (r_slot >= 4'd2) && (w_cand == r_prev1) && (w_cand == r_prev2);
  assign w_colour = (r_slot < r_len) ? (w_triple ? rotl_colour(w_cand) : w_cand) : BLACK;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_seq   <= '0;
      r_prev1 <= BLACK;
      r_prev2 <= BLACK;
    end else if (r_state == ST_FILL) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (r_slot == 4'(i)) begin
          r_seq[4*i +: 4] <= w_colour;
        end
      end
      r_prev2 <= r_prev1;
      r_prev1 <= w_colour;
    end
  end

  assign coloursequence = r_seq;
  assign seqLength      = r_len;
  assign level          = r_level;

endmodule
